// File: rtl/lsr_pkg.sv
// Shared constants for the logical-shift-right arbiter: FSM encoding and requester IDs.
package lsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } lsr_state_e;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

endpackage

// File: rtl/lsr32_core.sv
// Combinational 32-bit logical right shift; vacated upper bits are zero-filled.
module lsr32_core
  import lsr_pkg::*;
(
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  result
);

  assign result = data >> shamt;

endmodule

// File: rtl/lsr_arbiter.sv
// Two-requester round-robin front end for a single shared shifter: one transaction
// in flight, IDLE -> EXEC -> RESP, with the response held until the consumer takes it.
module lsr_arbiter
  import lsr_pkg::*;
#(
  parameter logic FIRST_GRANT = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [DATA_W-1:0]  a_data,
  input  logic [SHAMT_W-1:0] a_shamt,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [DATA_W-1:0]  b_data,
  input  logic [SHAMT_W-1:0] b_shamt,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_id,
  output logic               busy
);

  lsr_state_e         state_q, state_d;
  logic               prio_q, prio_d;
  logic [DATA_W-1:0]  op_data_q, op_data_d;
  logic [SHAMT_W-1:0] op_shamt_q, op_shamt_d;
  logic               op_id_q, op_id_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_id_q, rsp_id_d;
  logic               grant_a, grant_b;
  logic [DATA_W-1:0]  shift_res;

  lsr32_core u_core (
    .data   (op_data_q),
    .shamt  (op_shamt_q),
    .result (shift_res)
  );

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    op_data_d  = op_data_q;
    op_shamt_d = op_shamt_q;
    op_id_d    = op_id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A lone requester always wins; a tie goes to whoever holds priority.
        grant_b = b_valid && (!a_valid || prio_q == ID_B);
        grant_a = a_valid && !grant_b;
        if (grant_a) begin
          op_data_d  = a_data;
          op_shamt_d = a_shamt;
          op_id_d    = ID_A;
          prio_d     = ID_B;
          state_d    = ST_EXEC;
        end else if (grant_b) begin
          op_data_d  = b_data;
          op_shamt_d = b_shamt;
          op_id_d    = ID_B;
          prio_d     = ID_A;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d = shift_res;
        rsp_id_d   = op_id_q;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      prio_q     <= FIRST_GRANT;
      op_data_q  <= '0;
      op_shamt_q <= '0;
      op_id_q    <= ID_A;
      rsp_data_q <= '0;
      rsp_id_q   <= ID_A;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      op_data_q  <= op_data_d;
      op_shamt_q <= op_shamt_d;
      op_id_q    <= op_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  // Ready is combinational, so it is masked while reset is held.
  assign a_ready   = grant_a && !rst;
  assign b_ready   = grant_b && !rst;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lsr_arbiter.sv
// Self-checking bench for lsr_arbiter: directed vector table, corner-case sequences,
// and a randomized run against a transaction-level reference model.
module tb_lsr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [31:0] a_data = '0, b_data = '0;
  logic [4:0]  a_shamt = '0, b_shamt = '0;
  logic        rsp_ready = 1'b0;
  logic        a_ready, b_ready, rsp_valid, rsp_id, busy;
  logic [31:0] rsp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsr_arbiter #(.FIRST_GRANT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_shamt(a_shamt),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_shamt(b_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );

  typedef struct {
    logic        av, bv;
    logic [31:0] ad, bd;
    logic [4:0]  as, bs;
    logic        exp_id;
    logic [31:0] exp_data;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference shift from arithmetic: divide by 2**shamt.
  function automatic logic [31:0] ref_lsr(input logic [31:0] d, input logic [4:0] s);
    longint unsigned q;
    q = longint'(d) / (longint'(1) << s);
    return q[31:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; a_valid = 0; b_valid = 0; rsp_ready = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_txn(input vec_t v);
    @(negedge clk);
    a_valid = v.av; b_valid = v.bv; a_data = v.ad; b_data = v.bd;
    a_shamt = v.as; b_shamt = v.bs; rsp_ready = 0;
    #1;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("grant_a_ready", {31'd0, a_ready}, {31'd0, v.exp_id == 1'b0});
    chk("grant_b_ready", {31'd0, b_ready}, {31'd0, v.exp_id == 1'b1});
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
    chk("exec_busy", {31'd0, busy}, 32'd1);
    chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("resp_data", rsp_data, v.exp_data);
    chk("resp_id", {31'd0, rsp_id}, {31'd0, v.exp_id});
    rsp_ready = 1;
    @(posedge clk); #1;
    chk("post_resp_busy", {31'd0, busy}, 32'd0);
    chk("post_resp_valid", {31'd0, rsp_valid}, 32'd0);
    rsp_ready = 0;
  endtask

  vec_t vecs[6];

  initial begin
    // Priority travels through the table: A-only, B-only, then ties alternate.
    vecs[0] = '{1, 0, 32'h8000_0000, 32'h0, 5'd31, 5'd0, 1'b0, 32'h0000_0001};
    vecs[1] = '{0, 1, 32'h0, 32'h0000_000F, 5'd0, 5'd0, 1'b1, 32'h0000_000F};
    vecs[2] = '{1, 1, 32'hDEAD_BEEF, 32'h1, 5'd0, 5'd1, 1'b0, 32'hDEAD_BEEF};
    vecs[3] = '{1, 1, 32'h1, 32'hF000_0000, 5'd1, 5'd28, 1'b1, 32'h0000_000F};
    vecs[4] = '{1, 0, 32'h1234_5678, 32'h0, 5'd8, 5'd0, 1'b0, 32'h0012_3456};
    vecs[5] = '{1, 1, 32'h5, 32'hFFFF_FFFF, 5'd2, 5'd31, 1'b1, 32'h0000_0001};

    // Reset state, with a request pending to show ready is masked.
    a_valid = 1; b_valid = 1;
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
    a_valid = 0; b_valid = 0;
    @(negedge clk); rst = 0;
    repeat (2) begin
      @(negedge clk); #1;
      chk("idle_none_busy", {31'd0, busy}, 32'd0);
      chk("idle_none_ready", {30'd0, a_ready, b_ready}, 32'd0);
    end

    foreach (vecs[i]) do_txn(vecs[i]);

    // Back-to-back contention: responses must alternate A,B,A.
    do_reset();
    begin
      logic ids[$];
      logic [31:0] dats[$];
      logic last_g;
      bit have_g;
      have_g = 0; last_g = 0;
      @(negedge clk);
      a_valid = 1; b_valid = 1; rsp_ready = 1;
      a_data = 32'hFFFF_FFFF; a_shamt = 5'd4;
      b_data = 32'h00E1_ADE1; b_shamt = 5'd5;
      for (int c = 0; c < 30 && ids.size() < 3; c++) begin
        #1;
        if (a_ready || b_ready) begin
          if (have_g && last_g == b_ready) begin
            errors++;
            $display("FAIL rr_repeat_grant actual=%0d expected=%0d", b_ready, !last_g);
          end
          last_g = b_ready; have_g = 1;
        end
        if (rsp_valid) begin ids.push_back(rsp_id); dats.push_back(rsp_data); end
        @(negedge clk);
      end
      a_valid = 0; b_valid = 0;
      chk("rr_count", ids.size(), 3);
      if (ids.size() == 3) begin
        chk("rr_id0", {31'd0, ids[0]}, 32'd0);
        chk("rr_data0", dats[0], 32'h0FFF_FFFF);
        chk("rr_id1", {31'd0, ids[1]}, 32'd1);
        chk("rr_data1", dats[1], 32'h0007_0D6F);
        chk("rr_id2", {31'd0, ids[2]}, 32'd0);
        chk("rr_data2", dats[2], 32'h0FFF_FFFF);
      end
      rsp_ready = 0;
    end

    // Back-pressure: response holds while rsp_ready is low, requests ignored.
    do_reset();
    @(negedge clk);
    a_valid = 1; a_data = 32'hA5A5_0000; a_shamt = 5'd16;
    @(posedge clk); #1;
    b_valid = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data", rsp_data, 32'h0000_A5A5);
      chk("bp_id", {31'd0, rsp_id}, 32'd0);
      chk("bp_readies", {30'd0, a_ready, b_ready}, 32'd0);
      @(posedge clk); #1;
    end
    a_valid = 0; b_valid = 0; rsp_ready = 1;
    @(posedge clk); #1;
    chk("bp_release_busy", {31'd0, busy}, 32'd0);
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    rsp_ready = 0;

    // Async reset mid-EXEC: in-flight work dropped, priority back to FIRST_GRANT.
    do_reset();
    @(negedge clk);
    a_valid = 1; a_data = 32'hFFFF_0000; a_shamt = 5'd3;
    @(posedge clk); #1;
    a_valid = 0;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1 rst = 1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_rsp_data", rsp_data, 32'd0);
    #1 rst = 0;
    rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("arst_no_stale", {31'd0, rsp_valid}, 32'd0);
    end
    rsp_ready = 0;
    a_valid = 1; b_valid = 1;
    #1;
    chk("arst_grant_a", {31'd0, a_ready}, 32'd1);
    chk("arst_grant_b", {31'd0, b_ready}, 32'd0);
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;

    // Randomized run against a transaction-level model.
    do_reset();
    begin
      int          phase;   // 0 waiting for a grant, 1 computing, 2 presenting result
      logic        m_prio, m_id, win, ea, eb;
      logic [31:0] m_res;
      phase = 0; m_prio = 0; m_id = 0; m_res = '0;
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        a_valid = ($urandom_range(0, 2) != 0);
        b_valid = ($urandom_range(0, 2) != 0);
        a_data = $urandom; b_data = $urandom;
        a_shamt = 5'($urandom_range(0, 31));
        b_shamt = 5'($urandom_range(0, 31));
        rsp_ready = ($urandom_range(0, 1) != 0);
        #1;
        win = (a_valid && b_valid) ? m_prio : b_valid;
        ea = (phase == 0) && (a_valid || b_valid) && !win;
        eb = (phase == 0) && (a_valid || b_valid) && win;
        chk("rnd_a_ready", {31'd0, a_ready}, {31'd0, ea});
        chk("rnd_b_ready", {31'd0, b_ready}, {31'd0, eb});
        chk("rnd_busy", {31'd0, busy}, {31'd0, phase != 0});
        chk("rnd_rsp_valid", {31'd0, rsp_valid}, {31'd0, phase == 2});
        if (phase == 2) begin
          chk("rnd_rsp_data", rsp_data, m_res);
          chk("rnd_rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
        end
        @(posedge clk);
        if (phase == 0 && (ea || eb)) begin
          m_id   = win;
          m_res  = win ? ref_lsr(b_data, b_shamt) : ref_lsr(a_data, a_shamt);
          m_prio = !win;
          phase  = 1;
        end else if (phase == 1) begin
          phase = 2;
        end else if (phase == 2 && rsp_ready) begin
          phase = 0;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsr_arbiter.md
LSR_ARBITER -- requirements
Module: lsr_arbiter

Interface
REQ-001 SHALL have parameter FIRST_GRANT, default 0, selecting which requester (0=A, 1=B) holds priority out of reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have ports a_valid, input, 1 and b_valid, input, 1, request valid from A and B.
REQ-005 SHALL have ports a_ready, output, 1 and b_ready, output, 1, request accepted this cycle.
REQ-006 SHALL have ports a_data, b_data, input, 32, operand to shift.
REQ-007 SHALL have ports a_shamt, b_shamt, input, 5, right-shift amount 0..31.
REQ-008 SHALL have port rsp_valid, output, 1, result available.
REQ-009 SHALL have port rsp_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port rsp_data, output, 32, logical-right-shift result.
REQ-011 SHALL have port rsp_id, output, 1, requester that owns rsp_data (0=A, 1=B).
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP; only transitions IDLE->EXEC, EXEC->RESP, RESP->IDLE.
REQ-014 In IDLE, grant: only one valid -> that requester; both valid -> requester holding priority; none -> stay IDLE, both ready low.
REQ-015 x_ready SHALL be combinational, high only in IDLE for the granted requester; at most one ready high per cycle.
REQ-016 On a handshake (valid and ready high), SHALL capture data, shamt and id into operand registers and enter EXEC.
REQ-017 On each accept, priority SHALL move to the non-accepted requester (round-robin), including when only one was valid.
REQ-018 In EXEC, SHALL register rsp_data = operand >> shamt, zero-filling the upper shamt bits; shamt 0 passes operand unchanged.
REQ-019 On the EXEC->RESP edge, rsp_valid SHALL rise; first-cycle latency from accept edge to rsp_valid high is 2 clocks.
REQ-020 In RESP, rsp_valid, rsp_data and rsp_id SHALL hold stable until rsp_ready is high; state then returns to IDLE and rsp_valid falls on that edge.
REQ-021 No new request SHALL be accepted in EXEC or RESP; request inputs ignored there; minimum issue interval 3 clocks.
REQ-022 Requester valid deasserting without a handshake SHALL cause no state change.
REQ-023 rsp_ready high outside RESP SHALL be ignored.

Reset
REQ-024 On rst high, state SHALL go to IDLE immediately, without waiting for clk.
REQ-025 Reset values: rsp_valid 0, rsp_data 0, rsp_id 0, busy 0, a_ready/b_ready 0 while rst high, priority = FIRST_GRANT.
REQ-026 Reset in EXEC or RESP SHALL discard the in-flight transaction; no response is produced for it after release.

Structure
REQ-027 State encoding and requester-ID constants SHALL live in shared package lsr_pkg.
REQ-028 The shift SHALL be a single combinational sub-module lsr32_core (32-bit data, 5-bit amount, 32-bit result), instantiated once.

Verification
REQ-029 Reset, FIRST_GRANT=0, a_valid only, a_data=0x8000_0000, a_shamt=31 -> rsp_valid 2 clocks after accept, rsp_data=0x0000_0001, rsp_id=0.
REQ-030 b_valid only, b_data=0x0000_000F, b_shamt=0 -> rsp_data=0x0000_000F, rsp_id=1.
REQ-031 Both valid every cycle, rsp_ready=1, a_data=0xFFFF_FFFF shamt 4, b_data=0x00E1_ADE1 shamt 5 -> responses alternate A,B,A with 0x0FFF_FFFF and 0x0007_0D6F; no requester granted twice in a row.
REQ-032 rsp_ready held low 5 clocks in RESP -> rsp_valid, rsp_data, rsp_id stable; a_ready and b_ready low throughout; IDLE one edge after rsp_ready rises.
REQ-033 rst pulsed asynchronously mid-EXEC -> busy 0 and rsp_valid 0 immediately; no stale response after release; next grant follows FIRST_GRANT.
